spi_byte_master: RTL and testbench

- SPI mode-0 byte engine directly downstream of the SD command/control logic in SPI_top; drives the SD card pins o_clk, o_mosi, o_cs and samples i_miso.
- Accepts one byte per valid/ready handshake, shifts it out MSB-first and returns the byte received simultaneously.
- Per-byte chip-select level lets the upstream sequencer issue the SD power-up dummy clocks with CS high and commands with CS low.

---
 rtl/spi_byte_master_if.sv | 25 ++
 rtl/spi_byte_master.sv | 124 ++++++++++++
 tb/tb_spi_byte_master.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_master_if.sv
// spi_byte_master_if: byte-level handshake and SD card pin bundle for spi_byte_master.
// The master modport is the engine's view; the slave modport is the view of the
// upstream sequencer and the card side.
interface spi_byte_master_if;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       i_cs_n;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       i_miso;
    logic       o_mosi;
    logic       o_clk;
    logic       o_cs;

    modport master (
        input  i_tx_data, i_tx_valid, i_cs_n, i_miso,
        output o_tx_ready, o_rx_data, o_rx_valid, o_mosi, o_clk, o_cs
    );

    modport slave (
        output i_tx_data, i_tx_valid, i_cs_n, i_miso,
        input  o_tx_ready, o_rx_data, o_rx_valid, o_mosi, o_clk, o_cs
    );
endinterface

// File: rtl/spi_byte_master.sv
// spi_byte_master: SPI mode-0 byte engine for the SD card interface.
// Accepts one byte per valid/ready handshake, shifts it out while sampling MISO,
// and returns the received byte with a one-cycle o_rx_valid pulse.
// SCLK half-period is CLK_DIV system clocks (1..255); SCLK idles low.
// Optional macro SPI_LSB_FIRST_EN: send and assemble bytes LSB-first instead of
// MSB-first. Timing is the same either way.
module spi_byte_master #(
    parameter int CLK_DIV = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    spi_byte_master_if.master      bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0] state_reg;
    logic [7:0] div_reg;
    logic [2:0] bit_reg;
    logic [7:0] tx_reg;
    logic [7:0] rx_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       ready_reg;
    logic       mosi_reg;
    logic       sclk_reg;
    logic       cs_reg;

    // The shifter always works MSB-first; bit order selection is done by
    // reversing the byte on the way in and on the way out.
    logic [7:0] tx_ordered;
    logic [7:0] rx_ordered;

`ifdef SPI_LSB_FIRST_EN
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reverse
            assign tx_ordered[gi] = bus.i_tx_data[7 - gi];
            assign rx_ordered[gi] = rx_reg[7 - gi];
        end
    endgenerate
`else
    assign tx_ordered = bus.i_tx_data;
    assign rx_ordered = rx_reg;
`endif

    // Byte engine: IDLE tracks CS and waits for a byte, SHIFT runs the SCLK
    // divider and moves bits, DONE publishes the received byte for one cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= ST_IDLE;
            div_reg      <= 8'd0;
            bit_reg      <= 3'd0;
            tx_reg       <= 8'd0;
            rx_reg       <= 8'd0;
            rx_data_reg  <= 8'd0;
            rx_valid_reg <= 1'b0;
            ready_reg    <= 1'b1;
            mosi_reg     <= 1'b1;
            sclk_reg     <= 1'b0;
            cs_reg       <= 1'b1;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    sclk_reg <= 1'b0;
                    mosi_reg <= 1'b1;
                    cs_reg   <= bus.i_cs_n;
                    if (bus.i_tx_valid && ready_reg) begin
                        // First bit goes on the wire now so it is stable
                        // for the first rising SCLK edge.
                        mosi_reg  <= tx_ordered[7];
                        tx_reg    <= {tx_ordered[6:0], 1'b0};
                        ready_reg <= 1'b0;
                        div_reg   <= 8'd0;
                        bit_reg   <= 3'd0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg  <= 8'd0;
                        sclk_reg <= ~sclk_reg;
                        if (!sclk_reg) begin
                            // Rising SCLK: sample the card's bit.
                            rx_reg <= {rx_reg[6:0], bus.i_miso};
                        end else if (bit_reg == 3'd7) begin
                            // Falling edge after the eighth bit ends the byte.
                            state_reg <= ST_DONE;
                        end else begin
                            // Falling SCLK: present the next bit.
                            mosi_reg <= tx_reg[7];
                            tx_reg   <= {tx_reg[6:0], 1'b0};
                            bit_reg  <= bit_reg + 3'd1;
                        end
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    rx_data_reg  <= rx_ordered;
                    rx_valid_reg <= 1'b1;
                    ready_reg    <= 1'b1;
                    mosi_reg     <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_tx_ready = ready_reg;
    assign bus.o_rx_data  = rx_data_reg;
    assign bus.o_rx_valid = rx_valid_reg;
    assign bus.o_mosi     = mosi_reg;
    assign bus.o_clk      = sclk_reg;
    assign bus.o_cs       = cs_reg;

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: self-checking bench for spi_byte_master with CLK_DIV=2.
// A table of directed transfers, a few hand-written multi-cycle sequences and
// random transfers are checked against a bit-order/latency reference model.
module tb_spi_byte_master;

    localparam int D   = 2;
    localparam int LAT = 16 * D + 1;   // accept edge to o_rx_valid edge

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    spi_byte_master_if bus ();

    spi_byte_master #(.CLK_DIV(D)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sl;
        logic       cs_n;
        int         mode;     // 0 plain, 1 busy valid pulse, 2 cs toggle mid-byte
        logic [7:0] exp_rx;
        int         exp_lat;
    } vec_t;

    vec_t vecs [7];

    // Reference: the i-th bit that appears on the wire for byte b.
    function automatic logic wire_bit(input logic [7:0] b, input int i);
`ifdef SPI_LSB_FIRST_EN
        return b[i];
`else
        return b[7 - i];
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One transfer with a card model that shifts sl out on falling SCLK.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sl, input logic cs,
                            input int mode, input logic [7:0] exp_rx, input int exp_lat);
        int         wt, rises, falls, pulses, lat, cs_bad;
        logic       prev_clk, ready_at;
        logic [7:0] got_wire, exp_wire, got_rx;
        wt = 0;
        while (bus.o_tx_ready !== 1'b1 && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        chk("ready_before", {31'd0, bus.o_tx_ready}, 32'd1);
        bus.i_miso     = wire_bit(sl, 0);
        bus.i_tx_data  = tx;
        bus.i_cs_n     = cs;
        bus.i_tx_valid = 1'b1;
        @(posedge clk);  // T0
        rises = 0; falls = 0; pulses = 0; lat = -1; cs_bad = 0;
        prev_clk = 1'b0; ready_at = 1'b0;
        got_wire = 8'd0; exp_wire = 8'd0; got_rx = 8'd0;
        for (int n = 0; n <= LAT + 6; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.i_tx_valid = 1'b0;
                chk("ready_busy", {31'd0, bus.o_tx_ready}, 32'd0);
            end
            if (mode == 1 && n == 10) begin
                bus.i_tx_data  = 8'h00;
                bus.i_tx_valid = 1'b1;
            end
            if (mode == 1 && n == 11) bus.i_tx_valid = 1'b0;
            if (mode == 2 && n == 10) bus.i_cs_n = ~cs;
            if (n <= LAT && bus.o_cs !== cs) cs_bad++;
            if (bus.o_clk === 1'b1 && prev_clk === 1'b0) begin
                if (rises < 8) begin
                    got_wire[7 - rises] = bus.o_mosi;
                    exp_wire[7 - rises] = wire_bit(tx, rises);
                end
                rises++;
                if (mode == 3 && rises == 4) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_clk", {31'd0, bus.o_clk}, 32'd0);
                    chk("abort_cs", {31'd0, bus.o_cs}, 32'd1);
                    chk("abort_mosi", {31'd0, bus.o_mosi}, 32'd1);
                    chk("abort_ready", {31'd0, bus.o_tx_ready}, 32'd1);
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    pulses = 0;
                    for (int k = 0; k < LAT + 5; k++) begin
                        @(negedge clk);
                        if (bus.o_rx_valid === 1'b1) pulses++;
                    end
                    chk("abort_no_rx_valid", pulses, 0);
                    chk("abort_clk_idle", {31'd0, bus.o_clk}, 32'd0);
                    $display("xfer tx=%02h aborted by reset after %0d rising edges", tx, rises);
                    return;
                end
            end
            if (bus.o_clk === 1'b0 && prev_clk === 1'b1) begin
                falls++;
                if (falls < 8) bus.i_miso = wire_bit(sl, falls);
            end
            prev_clk = bus.o_clk;
            if (bus.o_rx_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat      = n;
                    got_rx   = bus.o_rx_data;
                    ready_at = bus.o_tx_ready;
                end
            end
        end
        chk("mosi_bits", {24'd0, got_wire}, {24'd0, exp_wire});
        chk("rising_edges", rises, 8);
        chk("rx_data", {24'd0, got_rx}, {24'd0, exp_rx});
        chk("rx_latency", lat, exp_lat);
        chk("rx_pulses", pulses, 1);
        chk("ready_at_done", {31'd0, ready_at}, 32'd1);
        chk("cs_held", cs_bad, 0);
        chk("clk_idle_low", {31'd0, bus.o_clk}, 32'd0);
        if (mode == 2) begin
            chk("cs_follows_after", {31'd0, bus.o_cs}, {31'd0, ~cs});
            bus.i_cs_n = cs;
        end
        $display("xfer tx=%02h card=%02h cs_n=%0d mode=%0d rx=%02h lat=%0d", tx, sl, cs, mode, got_rx, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts, last, bad_gap, rises, good, pulses;
        logic prev;
        logic [7:0] rtx, rsl;
        logic rcs;

        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 0, 8'h3C, LAT};
        vecs[1] = '{8'h00, 8'hFF, 1'b0, 0, 8'hFF, LAT};
        vecs[2] = '{8'h5A, 8'h96, 1'b1, 0, 8'h96, LAT};
        vecs[3] = '{8'h01, 8'h80, 1'b0, 0, 8'h80, LAT};
        vecs[4] = '{8'hA5, 8'h3C, 1'b0, 1, 8'h3C, LAT};
        vecs[5] = '{8'hC3, 8'h5A, 1'b0, 2, 8'h5A, LAT};
        vecs[6] = '{8'h7E, 8'h01, 1'b1, 2, 8'h01, LAT};

        bus.i_tx_data  = 8'h00;
        bus.i_tx_valid = 1'b0;
        bus.i_cs_n     = 1'b1;
        bus.i_miso     = 1'b1;

        // Reset values
        #12;
        chk("rst_clk", {31'd0, bus.o_clk}, 32'd0);
        chk("rst_mosi", {31'd0, bus.o_mosi}, 32'd1);
        chk("rst_cs", {31'd0, bus.o_cs}, 32'd1);
        chk("rst_ready", {31'd0, bus.o_tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, bus.o_rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, bus.o_rx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CS tracking in IDLE: o_cs follows i_cs_n one cycle later
        bus.i_cs_n = 1'b0;
        #1;
        chk("cs_idle_not_yet", {31'd0, bus.o_cs}, 32'd1);
        @(negedge clk);
        chk("cs_idle_low", {31'd0, bus.o_cs}, 32'd0);
        bus.i_cs_n = 1'b1;
        @(negedge clk);
        chk("cs_idle_high", {31'd0, bus.o_cs}, 32'd1);

        // Directed table
        for (int i = 0; i < 7; i++)
            run_xfer(vecs[i].tx, vecs[i].sl, vecs[i].cs_n, vecs[i].mode, vecs[i].exp_rx, vecs[i].exp_lat);

        // Dummy clocks: ten 0xFF bytes back-to-back with CS high
        bus.i_cs_n = 1'b1; bus.i_tx_data = 8'hFF; bus.i_miso = 1'b1; bus.i_tx_valid = 1'b1;
        accepts = 0; last = -1; bad_gap = 0; rises = 0; good = 0; pulses = 0;
        prev = bus.o_clk;
        for (int k = 0; k < 10 * (LAT + 1) + 20; k++) begin
            if (accepts == 10) bus.i_tx_valid = 1'b0;
            if (bus.o_tx_ready === 1'b1 && bus.i_tx_valid === 1'b1) begin
                if (last >= 0 && (cyc + 1 - last) != LAT + 1) bad_gap++;
                last = cyc + 1;
                accepts++;
            end
            if (bus.o_clk === 1'b1 && prev === 1'b0) begin
                rises++;
                if (bus.o_cs === 1'b1 && bus.o_mosi === 1'b1) good++;
            end
            prev = bus.o_clk;
            if (bus.o_rx_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        bus.i_tx_valid = 1'b0;
        chk("dummy_accepts", accepts, 10);
        chk("dummy_spacing", bad_gap, 0);
        chk("dummy_rises", rises, 80);
        chk("dummy_cs_mosi_high", good, 80);
        chk("dummy_rx_pulses", pulses, 10);
        $display("xfer dummy x10 accepts=%0d rises=%0d", accepts, rises);

        // Reset at the 4th rising SCLK, then a clean 0x40 transfer
        run_xfer(8'h55, 8'hAA, 1'b0, 3, 8'h00, 0);
        run_xfer(8'h40, 8'h95, 1'b0, 0, 8'h95, LAT);

        // Random transfers
        for (int i = 0; i < 12; i++) begin
            rtx = 8'($urandom_range(0, 255));
            rsl = 8'($urandom_range(0, 255));
            rcs = 1'($urandom_range(0, 1));
            run_xfer(rtx, rsl, rcs, 0, rsl, LAT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
